audio_sample_sequencer: RTL

Controller between the audio codec handshake (read_ready/read, write_ready/write) and the per-sample filter datapath: it captures one stereo sample from the codec, issues it to the datapath with a one-cycle strobe, waits for the datapath result, and queues it for the codec DAC side. It mutes the output while the filter delay line is filling and decouples ADC capture from DAC back-pressure with a 2-entry output queue. It sits at the top level between the codec core and the filter.

---
 rtl/audio_seq_pkg.sv | 19 +
 rtl/audio_seq_outq.sv | 54 +++++
 rtl/audio_sample_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/audio_seq_pkg.sv
// Shared types for the audio sample sequencer: capture FSM states, the stereo
// sample pair and the default sample width.
package audio_seq_pkg;

  localparam int SEQ_DATA_W = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ISSUE   = 2'd2,
    WAIT    = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic signed [SEQ_DATA_W-1:0] left;
    logic signed [SEQ_DATA_W-1:0] right;
  } stereo_t;

endpackage

// File: rtl/audio_seq_outq.sv
// Two-entry stereo FIFO between the datapath result and the codec DAC side.
// Push and pop may coincide at any occupancy; a push into a full queue without a pop is dropped.
module audio_seq_outq #(
  parameter int W = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_left_i,
  input  logic [W-1:0] push_right_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_left_o,
  output logic [W-1:0] head_right_o
);

  logic [W-1:0] left_q [2];
  logic [W-1:0] right_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      left_q[wr_ptr_q]  <= push_left_i;
      right_q[wr_ptr_q] <= push_right_i;
    end
  end

  assign count_o      = count_q;
  assign head_left_o  = left_q[rd_ptr_q];
  assign head_right_o = right_q[rd_ptr_q];

endmodule

// File: rtl/audio_sample_sequencer.sv
// Captures codec ADC samples, hands them to the filter datapath, mutes output while
// the delay line fills, and queues results for the DAC. Optional SEQ_STATS_EN adds stall/underrun counters.
module audio_sample_sequencer
  import audio_seq_pkg::*;
#(
  parameter int DATA_W  = SEQ_DATA_W,
  parameter int WARMUP  = 64,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     read_ready,
  output logic                     read,
  input  logic signed [DATA_W-1:0] readdata_left,
  input  logic signed [DATA_W-1:0] readdata_right,
  input  logic                     write_ready,
  output logic                     write,
  output logic signed [DATA_W-1:0] writedata_left,
  output logic signed [DATA_W-1:0] writedata_right,
  output logic                     smp_valid,
  output logic signed [DATA_W-1:0] smp_left,
  output logic signed [DATA_W-1:0] smp_right,
  input  logic                     res_valid,
  input  logic signed [DATA_W-1:0] res_left,
  input  logic signed [DATA_W-1:0] res_right,
  output logic                     primed,
  output logic                     timeout_err,
  output seq_state_e               dbg_state
`ifdef SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         underrun_cnt
`endif
);

  // Handshakes: read and write are single-cycle strobes issued only while the codec
  // holds read_ready/write_ready; smp_valid is a one-cycle strobe with no back-pressure;
  // res_valid is honoured only in WAIT and ignored in every other state.

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WRM_W = $clog2(WARMUP + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [WRM_W-1:0] WRM_FULL = WRM_W'(WARMUP);

  seq_state_e              state_q, state_d;
  logic [DATA_W-1:0]       smp_left_q, smp_left_d, smp_right_q, smp_right_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [WRM_W-1:0]        warm_q, warm_d;
  logic                    primed_q, terr_q, terr_d;
  logic                    write_q;
  logic [DATA_W-1:0]       wr_left_q, wr_right_q;

  logic                    q_push, q_pop;
  logic [DATA_W-1:0]       push_left, push_right;
  logic [1:0]              q_count;
  logic [DATA_W-1:0]       head_left, head_right;

  always_comb begin
    state_d     = state_q;
    smp_left_d  = smp_left_q;
    smp_right_d = smp_right_q;
    timer_d     = timer_q;
    warm_d      = warm_q;
    terr_d      = terr_q;
    q_push      = 1'b0;
    push_left   = '0;
    push_right  = '0;
    unique case (state_q)
      IDLE: begin
        // Only capture when the queue can still take this sample's result.
        if (read_ready && (q_count != 2'd2)) begin
          smp_left_d  = readdata_left;
          smp_right_d = readdata_right;
          state_d     = CAPTURE;
        end
      end
      CAPTURE: state_d = ISSUE;
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (res_valid) begin
          q_push = 1'b1;
          if (primed_q) begin
            push_left  = res_left;
            push_right = res_right;
          end
          if (warm_q != WRM_FULL) warm_d = warm_q + 1'b1;
          state_d = IDLE;
        end else if (timer_q == TMR_LAST) begin
          q_push  = 1'b1;
          terr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q     <= IDLE;
      smp_left_q  <= '0;
      smp_right_q <= '0;
      timer_q     <= '0;
      warm_q      <= '0;
      primed_q    <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_left_q  <= smp_left_d;
      smp_right_q <= smp_right_d;
      timer_q     <= timer_d;
      warm_q      <= warm_d;
      primed_q    <= (warm_q == WRM_FULL);
      terr_q      <= terr_d;
    end
  end

  // DAC drain runs independently of the capture FSM; the write_q term keeps strobes apart.
  assign q_pop = write_ready && (q_count != 2'd0) && !write_q;

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      write_q    <= 1'b0;
      wr_left_q  <= '0;
      wr_right_q <= '0;
    end else begin
      write_q <= q_pop;
      if (q_pop) begin
        wr_left_q  <= head_left;
        wr_right_q <= head_right;
      end
    end
  end

  audio_seq_outq #(.W(DATA_W)) u_outq (
    .clk_i        (CLOCK_50),
    .rst_ni       (reset),
    .push_i       (q_push),
    .push_left_i  (push_left),
    .push_right_i (push_right),
    .pop_i        (q_pop),
    .count_o      (q_count),
    .head_left_o  (head_left),
    .head_right_o (head_right)
  );

  assign read            = (state_q == CAPTURE);
  assign smp_valid       = (state_q == ISSUE);
  assign smp_left        = smp_left_q;
  assign smp_right       = smp_right_q;
  assign write           = write_q;
  assign writedata_left  = wr_left_q;
  assign writedata_right = wr_right_q;
  assign primed          = primed_q;
  assign timeout_err     = terr_q;
  assign dbg_state       = state_q;

`ifdef SEQ_STATS_EN
  logic             blocked, blocked_q, starved, starved_q;
  logic [CNT_W-1:0] stall_q, underrun_q;

  assign blocked = (state_q == IDLE) && read_ready && (q_count == 2'd2);
  assign starved = write_ready && (q_count == 2'd0) && primed_q;

  // Both counters count onsets of a condition, not the cycles it lasts.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      blocked_q  <= 1'b0;
      starved_q  <= 1'b0;
      stall_q    <= '0;
      underrun_q <= '0;
    end else begin
      blocked_q <= blocked;
      starved_q <= starved;
      if (blocked && !blocked_q && (stall_q != '1))    stall_q    <= stall_q + 1'b1;
      if (starved && !starved_q && (underrun_q != '1)) underrun_q <= underrun_q + 1'b1;
    end
  end

  assign stall_cnt    = stall_q;
  assign underrun_cnt = underrun_q;
`else
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end
`endif

endmodule
